// File: rtl/conv_out_collector_if.sv
// Stream bundle between the convolution core, the collector and the writeback path.
// The collector owns the "master" view: it sinks the T-chain word stream and
// sources the row-parallel vector stream. The environment uses the "slave" view.
interface conv_out_collector_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int TOTAL_UNITS = 8
);
    logic [DATA_WIDTH-1:0]             t_in;
    logic                              t_valid;
    logic                              t_ready;
    logic [DATA_WIDTH*TOTAL_UNITS-1:0] m_data;
    logic                              m_valid;
    logic                              m_ready;
    logic                              m_last;

    modport master (
        input  t_in, t_valid, m_ready,
        output t_ready, m_data, m_valid, m_last
    );

    modport slave (
        output t_in, t_valid, m_ready,
        input  t_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/conv_out_collector.sv
// Collects the serial T-chain result stream, applies optional ReLU, packs
// TOTAL_UNITS words into one vector (first word in lane 0) and buffers
// vectors in a 2-entry FIFO for the writeback path. m_last marks the final
// vector of every VECS_PER_BURST-vector shift-out burst.
module conv_out_collector #(
    parameter int DATA_WIDTH     = 16,
    parameter int TOTAL_UNITS    = 8,
    parameter int VECS_PER_BURST = 3
) (
    input  logic                    clk,
    input  logic                    rstn,     // active-high synchronous reset
    input  logic                    clear,
    input  logic                    relu_en,
    conv_out_collector_if.master    bus,
    output logic                    overflow
);
    localparam int VW = DATA_WIDTH * TOTAL_UNITS;
    localparam int FW = (TOTAL_UNITS > 1) ? $clog2(TOTAL_UNITS) : 1;
    localparam int BW = (VECS_PER_BURST > 1) ? $clog2(VECS_PER_BURST) : 1;
    localparam logic [FW-1:0] LAST_LANE = FW'(TOTAL_UNITS - 1);
    localparam logic [BW-1:0] LAST_VEC  = BW'(VECS_PER_BURST - 1);

    logic [DATA_WIDTH-1:0]    word;
    logic [VW-DATA_WIDTH-1:0] asm_q;      // lanes 0..TOTAL_UNITS-2 of the vector in progress
    logic [FW-1:0]            fill_q;
    logic [BW-1:0]            burst_q;
    logic [VW-1:0]            slot0_q, slot1_q;   // slot0 is the FIFO head
    logic                     last0_q, last1_q;
    logic [1:0]               count_q;
    logic                     accept, push, pop, push_last;
    logic [VW-1:0]            push_vec;

    // Stall only when the closing word of a vector would need a FIFO slot.
    assign bus.t_ready = (count_q != 2'd2) || (fill_q != LAST_LANE);
    assign accept      = bus.t_valid && bus.t_ready;
    assign push        = accept && (fill_q == LAST_LANE);
    assign pop         = (count_q != 2'd0) && bus.m_ready;

    assign word      = (relu_en && bus.t_in[DATA_WIDTH-1]) ? '0 : bus.t_in;
    assign push_vec  = {word, asm_q};
    assign push_last = (burst_q == LAST_VEC);

    assign bus.m_data  = slot0_q;
    assign bus.m_last  = last0_q;
    assign bus.m_valid = (count_q != 2'd0);

    // Assembly lanes: write the accepted word into its lane.
    // NOTE: no reset here; a lane is always rewritten before the vector that
    // contains it is pushed, so stale contents after reset/clear never escape.
    always_ff @(posedge clk) begin
        for (int k = 0; k < TOTAL_UNITS - 1; k++) begin
            if (accept && !clear && (fill_q == FW'(k))) begin
                asm_q[k*DATA_WIDTH +: DATA_WIDTH] <= word;
            end
        end
    end

    // Counters and FIFO: reset beats clear, clear beats accept and pop.
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rstn || clear) begin
            fill_q  <= '0;
            burst_q <= '0;
            count_q <= 2'd0;
            slot0_q <= '0;
            slot1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            if (accept) begin
                fill_q <= (fill_q == LAST_LANE) ? '0 : fill_q + 1'b1;
            end
            if (push) begin
                burst_q <= push_last ? '0 : burst_q + 1'b1;
            end
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        slot0_q <= push_vec;
                        last0_q <= push_last;
                    end else begin
                        slot1_q <= push_vec;
                        last1_q <= push_last;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    last0_q <= last1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry: the new vector becomes head.
                    slot0_q <= push_vec;
                    last0_q <= push_last;
                end
                default: ;
            endcase
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            overflow <= 1'b0;
        end else if (bus.t_valid && !bus.t_ready) begin
            overflow <= 1'b1;
        end
    end
endmodule

// File: doc/conv_out_collector.md
# conv_out_collector

Downstream stage of the convolution core. Captures the serial result stream shifted out of the core's T-chain (one DATA_WIDTH word per valid cycle), applies optional ReLU, and regroups every TOTAL_UNITS words into one row-parallel output vector. Vectors are buffered in a 2-entry FIFO and presented on a valid/ready master port for the output DMA/writeback path.

## Interface
- DATA_WIDTH, 16, width of one result word
- TOTAL_UNITS, 8, conv units per core, so words per output vector
- VECS_PER_BURST, 3, vectors per T-chain shift-out burst (chains T1..T3); sets m_last cadence
- clk  in  1  sole clock, all state on rising edge
- rstn  in  1  reset; synchronous, active-high (1 = reset), name kept per codebase
- clear  in  1  synchronous flush: zeroes fill counter, burst counter, FIFO; does not clear overflow
- relu_en  in  1  when 1, negative words (MSB=1) are replaced by 0 at capture
- t_in  in  DATA_WIDTH  result word from core T_out
- t_valid  in  1  t_in valid this cycle
- t_ready  out  1  collector can accept a word this cycle
- m_data  out  DATA_WIDTH*TOTAL_UNITS  output vector, lane k = bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
- m_valid  out  1  m_data/m_last valid
- m_ready  in  1  consumer accepts
- m_last  out  1  marks final vector of a burst
- overflow  out  1  sticky: a word arrived with t_valid=1, t_ready=0

## Operation
- Accept = t_valid & t_ready. On accept, word (post-ReLU) written to lane fill_cnt of the assembly register; fill_cnt increments.
- First accepted word of a vector goes to lane 0 (core unit 0 emerges first), last to lane TOTAL_UNITS-1.
- When the word at fill_cnt = TOTAL_UNITS-1 is accepted: completed vector (including that word) pushed into FIFO, fill_cnt wraps to 0, burst_cnt increments; entry tagged last when burst_cnt = VECS_PER_BURST-1, then burst_cnt wraps to 0.
- FIFO: 2 entries, head drives m_data/m_last; m_valid = FIFO non-empty. Pop on m_valid & m_ready.
- t_ready = (fifo_count < 2) | (fill_cnt != TOTAL_UNITS-1). Must not depend on m_ready (no combinational path m_ready -> t_ready).
- Simultaneous push and pop: count unchanged; popped entry is old head, pushed entry goes behind remaining entry (count 1 -> 1 with new head = pushed vector; count 2 never pushes).
- t_valid while t_ready=0: word dropped, no counter changes, overflow set to 1 and held until rstn.
- relu_en sampled per word at accept; ReLU on two's-complement, no other arithmetic, no saturation.
- clear has priority over accept/pop in the same cycle; word presented with clear is discarded.
- rstn has priority over everything, including clear.

## Timing
- Reset values: t_ready=1, m_valid=0, m_data=0, m_last=0, overflow=0, fill_cnt=0, burst_cnt=0, fifo_count=0.
- Latency: last word of vector accepted at edge N -> m_valid=1 in the cycle after edge N (1 cycle).
- Throughput: one word/cycle sustained while m_ready=1; one vector per TOTAL_UNITS cycles.
- m_data/m_last held stable while m_valid=1 and m_ready=0.
- Reset or clear mid-vector: partial vector discarded; next accepted word lands in lane 0; burst restarts at vector 0.
- Stall only asserted on the cycle the final word of a vector would be accepted with FIFO full; earlier words of the next vector keep flowing into the assembly register.

## Test plan
- Reset then 8 words 0x0001..0x0008, relu_en=0, m_ready=1 -> one vector m_data=0x0008_0007_..._0001 (lane0=0x0001), m_valid 1 cycle after 8th accept, m_last=0.
- 24 consecutive words, m_ready=1 -> three vectors; m_last=0,0,1; fourth burst repeats 0,0,1.
- relu_en=1, words 0xFFFF,0x8000,0x7FFF,0x0000,... -> lanes 0x0000,0x0000,0x7FFF,0x0000; relu_en=0 passes 0xFFFF unchanged.
- m_ready=0, stream 24 words -> 2 vectors buffered, t_ready drops when fill_cnt=7, 24th word held off; keep t_valid high -> overflow=1 sticky; m_ready=1 -> vectors drain in order, t_ready returns 1.
- m_ready toggling 1/0 each cycle with FIFO at 1 entry during push -> no loss, no duplicate, order preserved, count checks against scoreboard.
- 5 words then clear (with t_valid=1 same cycle) -> no vector output; next 8 words form vector with first at lane 0; rstn mid-burst -> all outputs back to reset values, overflow=0.
